// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
//   Data-memory request/ready bus between the MEM stage (master) and the data
//   memory (slave).
//   req    master->slave  access request, held until ready
//   we     master->slave  write enable (1 = store, 0 = load)
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  lane-aligned store data
//   wstrb  master->slave  byte strobes for stores
//   ready  slave->master  access complete; rdata valid in the same cycle
//   rdata  slave->master  load word
// -----------------------------------------------------------------------------
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   RV32I memory-access stage. Issues loads/stores over the dmem bus, stalls
//   the pipeline until the access completes, aligns store lanes, extends load
//   data, and resolves branch/jump redirects.
//
//   Optional feature macro: MEM_MISALIGN_TRAP_EN
//     defined   : misaligned LH/LHU/SH/LW/SW issue no request and raise
//                 out_misalign (rd write suppressed, no stall).
//     undefined : out_misalign is 0; offending low address bits are ignored.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     in_*                EX/MEM pipeline register contents
//     dmem (master)       data-memory request/ready bus
//     stall               hold EX/MEM and all upstream stages
//     out_write_data      writeback value
//     out_reg_write       qualified rd write
//     out_write_reg       rd passthrough
//     out_pc_src          redirect fetch
//     out_target          redirect address
//     out_misalign        misaligned-access flag
// -----------------------------------------------------------------------------
module mem_access_stage (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                in_alu_result,
  input  logic                       in_zero,
  input  logic [2:0]                 in_funct3,
  input  logic [31:0]                in_mem_write_data,
  input  logic                       in_mem_write,
  input  logic                       in_mem_reg,
  input  logic                       in_reg_write,
  input  logic [4:0]                 in_write_reg,
  input  logic                       in_branch,
  input  logic                       in_jal,
  input  logic                       in_jalr,
  input  logic [31:0]                in_imm,
  input  logic [31:0]                in_PC,
  input  logic [31:0]                in_nextPC,
  mem_access_stage_if.master         dmem,
  output logic                       stall,
  output logic [31:0]                out_write_data,
  output logic                       out_reg_write,
  output logic [4:0]                 out_write_reg,
  output logic                       out_pc_src,
  output logic [31:0]                out_target,
  output logic                       out_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] load_q, load_d;

  logic        is_mem_s;
  logic        misalign_s;
  logic        stall_s;
  logic [31:0] store_wdata_s;
  logic [3:0]  store_wstrb_s;
  logic [7:0]  load_byte_s;
  logic [15:0] load_half_s;
  logic [31:0] load_ext_s;
  logic        taken_s;

  assign is_mem_s = in_mem_reg | in_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  // Halfwords need a[0]=0, words need a[1:0]=0; byte accesses are always legal.
  assign misalign_s = is_mem_s &
                      ((((in_funct3 == 3'b001) | (in_mem_reg & (in_funct3 == 3'b101))) & in_alu_result[0]) |
                       ((in_funct3 == 3'b010) & (in_alu_result[1:0] != 2'b00)));
`else
  assign misalign_s = 1'b0;
`endif

  // Store lane alignment: replicate the datum across lanes, strobe the target bytes.
  always_comb begin
    store_wdata_s = in_mem_write_data;
    store_wstrb_s = 4'b1111;
    case (in_funct3)
      3'b000: begin
        store_wdata_s = {4{in_mem_write_data[7:0]}};
        store_wstrb_s = 4'b0001 << in_alu_result[1:0];
      end
      3'b001: begin
        store_wdata_s = {2{in_mem_write_data[15:0]}};
        store_wstrb_s = in_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        store_wdata_s = in_mem_write_data;
        store_wstrb_s = 4'b1111;
      end
      default: begin
        store_wdata_s = in_mem_write_data;
        store_wstrb_s = 4'b1111;
      end
    endcase
  end

  // Load extraction from the captured word; halfwords select on a[1] only.
  always_comb begin
    load_half_s = in_alu_result[1] ? load_q[31:16] : load_q[15:0];
    case (in_alu_result[1:0])
      2'b00:   load_byte_s = load_q[7:0];
      2'b01:   load_byte_s = load_q[15:8];
      2'b10:   load_byte_s = load_q[23:16];
      2'b11:   load_byte_s = load_q[31:24];
      default: load_byte_s = load_q[7:0];
    endcase
    case (in_funct3)
      3'b000:  load_ext_s = {{24{load_byte_s[7]}}, load_byte_s};
      3'b001:  load_ext_s = {{16{load_half_s[15]}}, load_half_s};
      3'b010:  load_ext_s = load_q;
      3'b100:  load_ext_s = {24'h000000, load_byte_s};
      3'b101:  load_ext_s = {16'h0000, load_half_s};
      default: load_ext_s = load_q;
    endcase
  end

  // Branch condition; 100/110 and 101/111 rely on the ALU's compare bit.
  always_comb begin
    case (in_funct3)
      3'b000:  taken_s = in_zero;
      3'b001:  taken_s = ~in_zero;
      3'b100:  taken_s = in_alu_result[0];
      3'b110:  taken_s = in_alu_result[0];
      3'b101:  taken_s = ~in_alu_result[0];
      3'b111:  taken_s = ~in_alu_result[0];
      default: taken_s = 1'b0;
    endcase
  end

  // Access FSM next-state and dmem register loading.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    load_d  = load_q;
    stall_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mem_s && !misalign_s) begin
          stall_s = 1'b1;
          req_d   = 1'b1;
          we_d    = in_mem_write;
          addr_d  = {in_alu_result[31:2], 2'b00};
          wdata_d = store_wdata_s;
          wstrb_d = in_mem_write ? store_wstrb_s : 4'b0000;
          state_d = ST_WAIT;
        end else begin
          stall_s = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        if (dmem.ready) begin
          load_d  = dmem.rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        // Instruction retires this cycle; a following access starts from IDLE.
        stall_s = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        stall_s = 1'b0;
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and dmem register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      wstrb_q <= 4'b0000;
      load_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      load_q  <= load_d;
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.wstrb = wstrb_q;

  assign stall          = stall_s;
  assign out_misalign   = misalign_s;
  assign out_write_reg  = in_write_reg;
  assign out_reg_write  = in_reg_write & ~stall_s & ~misalign_s;
  assign out_pc_src     = in_jal | in_jalr | (in_branch & taken_s);
  assign out_target     = in_jalr ? {in_alu_result[31:1], 1'b0} : (in_PC + in_imm);
  assign out_write_data = (in_jal | in_jalr) ? in_nextPC :
                          (in_mem_reg ? load_ext_s : in_alu_result);

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Self-checking bench for mem_access_stage. Inputs are driven 1 time unit
//   after the rising edge, outputs are sampled on the falling edge. Expected
//   writeback values are queued when a load is issued and popped on retire.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_stage;
  logic        clk;
  logic        rst;
  logic [31:0] in_alu_result;
  logic        in_zero;
  logic [2:0]  in_funct3;
  logic [31:0] in_mem_write_data;
  logic        in_mem_write;
  logic        in_mem_reg;
  logic        in_reg_write;
  logic [4:0]  in_write_reg;
  logic        in_branch;
  logic        in_jal;
  logic        in_jalr;
  logic [31:0] in_imm;
  logic [31:0] in_PC;
  logic [31:0] in_nextPC;
  logic        stall;
  logic [31:0] out_write_data;
  logic        out_reg_write;
  logic [4:0]  out_write_reg;
  logic        out_pc_src;
  logic [31:0] out_target;
  logic        out_misalign;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  mem_access_stage_if dmem_if ();

  mem_access_stage dut (
    .clk              (clk),
    .rst              (rst),
    .in_alu_result    (in_alu_result),
    .in_zero          (in_zero),
    .in_funct3        (in_funct3),
    .in_mem_write_data(in_mem_write_data),
    .in_mem_write     (in_mem_write),
    .in_mem_reg       (in_mem_reg),
    .in_reg_write     (in_reg_write),
    .in_write_reg     (in_write_reg),
    .in_branch        (in_branch),
    .in_jal           (in_jal),
    .in_jalr          (in_jalr),
    .in_imm           (in_imm),
    .in_PC            (in_PC),
    .in_nextPC        (in_nextPC),
    .dmem             (dmem_if),
    .stall            (stall),
    .out_write_data   (out_write_data),
    .out_reg_write    (out_reg_write),
    .out_write_reg    (out_write_reg),
    .out_pc_src       (out_pc_src),
    .out_target       (out_target),
    .out_misalign     (out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    in_alu_result = 32'h0; in_zero = 1'b0; in_funct3 = 3'b000;
    in_mem_write_data = 32'h0; in_mem_write = 1'b0; in_mem_reg = 1'b0;
    in_reg_write = 1'b0; in_write_reg = 5'd0; in_branch = 1'b0;
    in_jal = 1'b0; in_jalr = 1'b0; in_imm = 32'h0; in_PC = 32'h0; in_nextPC = 32'h0;
    dmem_if.ready = 1'b0; dmem_if.rdata = 32'h0;
  endtask

  // Presents one load/store and serves it with ready in the w-th wait cycle.
  task automatic run_access(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int w,
                            output int st_cnt, output int rq_cnt,
                            output logic [31:0] o_addr, output logic [31:0] o_wdata,
                            output logic [3:0] o_wstrb, output logic o_we,
                            output logic [31:0] o_wb, output logic o_rw, output logic timed_out);
    @(posedge clk); #1;
    set_idle();
    in_mem_reg = ld; in_mem_write = ~ld; in_reg_write = ld; in_write_reg = 5'd7;
    in_funct3 = f3; in_alu_result = addr; in_mem_write_data = wd; dmem_if.rdata = rd;
    st_cnt = 0; rq_cnt = 0; timed_out = 1'b1;
    o_addr = 32'h0; o_wdata = 32'h0; o_wstrb = 4'b0000; o_we = 1'b0; o_wb = 32'h0; o_rw = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dmem_if.req) begin
        if (rq_cnt == 0) begin
          o_addr = dmem_if.addr; o_wdata = dmem_if.wdata; o_wstrb = dmem_if.wstrb; o_we = dmem_if.we;
        end
        rq_cnt++;
      end
      if (stall) st_cnt++;
      else begin
        o_wb = out_write_data; o_rw = out_reg_write; timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      dmem_if.ready = ((c + 1) == w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (dmem_if.req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%b want=0", dmem_if.req); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%b want=0", stall); end
    tests_run++; if ({dmem_if.addr, dmem_if.wdata, dmem_if.wstrb, dmem_if.we} !== 69'h0) begin tests_failed++; $display("FAIL reset_bus got=%h/%h/%b/%b want=0", dmem_if.addr, dmem_if.wdata, dmem_if.wstrb, dmem_if.we); end
    tests_run++; if (out_misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got=%b want=0", out_misalign); end
    @(posedge clk); #1; rst = 1'b0;
    // start a load and leave it waiting
    in_mem_reg = 1'b1; in_reg_write = 1'b1; in_funct3 = 3'b010; in_alu_result = 32'h0000_4000;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (dmem_if.req !== 1'b1 || stall !== 1'b1) begin tests_failed++; $display("FAIL wait_req got=%b/%b want=1/1", dmem_if.req, stall); end
    @(posedge clk); #1;
    rst = 1'b1; set_idle(); dmem_if.ready = 1'b1; dmem_if.rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (dmem_if.req !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL rst_wait got=%b/%b want=0/0", dmem_if.req, stall); end
    @(posedge clk); #1; rst = 1'b0; dmem_if.ready = 1'b0;
    @(negedge clk);
    tests_run++; if (dmem_if.req !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL post_rst got=%b/%b want=0/0", dmem_if.req, stall); end
  endtask

  task automatic test_store();
    int st, rq; logic [31:0] a, d, wb; logic [3:0] s; logic we, rw, to;
    run_access(1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1, st, rq, a, d, s, we, wb, rw, to);
    tests_run++; if (to || st != 2 || rq != 1) begin tests_failed++; $display("FAIL sb_timing got stall=%0d req=%0d to=%b want 2/1/0", st, rq, to); end
    tests_run++; if ({a, s, d, we} !== {32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1'b1}) begin tests_failed++; $display("FAIL sb_bus got=%h/%b/%h/%b want=00001000/1000/a5a5a5a5/1", a, s, d, we); end
    tests_run++; if (rw !== 1'b0) begin tests_failed++; $display("FAIL sb_regwrite got=%b want=0", rw); end
    run_access(1'b0, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 1, st, rq, a, d, s, we, wb, rw, to);
    tests_run++; if (to || {a, s, d} !== {32'h0000_1000, 4'b1100, 32'hBEEF_BEEF}) begin tests_failed++; $display("FAIL sh_bus got=%h/%b/%h want=00001000/1100/beefbeef", a, s, d); end
    run_access(1'b0, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, 2, st, rq, a, d, s, we, wb, rw, to);
    tests_run++; if (to || st != 3 || rq != 2) begin tests_failed++; $display("FAIL sw_timing got stall=%0d req=%0d want 3/2", st, rq); end
    tests_run++; if ({a, s, d} !== {32'h0000_1004, 4'b1111, 32'hCAFE_F00D}) begin tests_failed++; $display("FAIL sw_bus got=%h/%b/%h want=00001004/1111/cafef00d", a, s, d); end
  endtask

  task automatic test_load();
    int st, rq; logic [31:0] a, d, wb, e; logic [3:0] s; logic we, rw, to;
    exp_q.push_back(32'hFFFF_FF80);
    run_access(1'b1, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 3, st, rq, a, d, s, we, wb, rw, to);
    e = exp_q.pop_front();
    tests_run++; if (to || wb !== e) begin tests_failed++; $display("FAIL lb_data got=%h want=%h", wb, e); end
    tests_run++; if (st != 4 || {a, we} !== {32'h0000_2000, 1'b0} || rw !== 1'b1) begin tests_failed++; $display("FAIL lb_ctrl got stall=%0d addr=%h we=%b rw=%b want 4/00002000/0/1", st, a, we, rw); end
    exp_q.push_back(32'h0000_0080);
    run_access(1'b1, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 3, st, rq, a, d, s, we, wb, rw, to);
    e = exp_q.pop_front();
    tests_run++; if (to || wb !== e || st != 4) begin tests_failed++; $display("FAIL lbu_data got=%h stall=%0d want=%h/4", wb, st, e); end
    exp_q.push_back(32'hFFFF_8001);
    run_access(1'b1, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 1, st, rq, a, d, s, we, wb, rw, to);
    e = exp_q.pop_front();
    tests_run++; if (to || wb !== e) begin tests_failed++; $display("FAIL lh_data got=%h want=%h", wb, e); end
    exp_q.push_back(32'h0000_8001);
    run_access(1'b1, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 1, st, rq, a, d, s, we, wb, rw, to);
    e = exp_q.pop_front();
    tests_run++; if (to || wb !== e) begin tests_failed++; $display("FAIL lhu_data got=%h want=%h", wb, e); end
    exp_q.push_back(32'h1234_5678);
    run_access(1'b1, 3'b010, 32'h0000_2004, 32'h0, 32'h1234_5678, 1, st, rq, a, d, s, we, wb, rw, to);
    e = exp_q.pop_front();
    tests_run++; if (to || wb !== e || st != 2) begin tests_failed++; $display("FAIL lw_data got=%h stall=%0d want=%h/2", wb, st, e); end
  endtask

  task automatic drive_ctrl(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                            input logic z, input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm);
    @(posedge clk); #1;
    set_idle();
    in_branch = br; in_jal = jal; in_jalr = jalr; in_funct3 = f3; in_zero = z;
    in_alu_result = alu; in_PC = pc; in_imm = imm; in_nextPC = pc + 32'd4;
    in_reg_write = jal | jalr | ~br; in_write_reg = 5'd3;
    dmem_if.ready = 1'b1; // a stray ready outside WAIT must be ignored
    @(negedge clk);
  endtask

  task automatic test_branch_jump();
    drive_ctrl(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 32'h0000_0001, 32'h0000_0100, 32'hFFFF_FFF8);
    tests_run++; if ({out_pc_src, out_target, stall} !== {1'b1, 32'h0000_00F8, 1'b0}) begin tests_failed++; $display("FAIL bne_taken got=%b/%h/%b want=1/000000f8/0", out_pc_src, out_target, stall); end
    drive_ctrl(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0000_0001, 32'h0000_0100, 32'h0000_0010);
    tests_run++; if (out_pc_src !== 1'b0) begin tests_failed++; $display("FAIL beq_not_taken got=%b want=0", out_pc_src); end
    drive_ctrl(1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 32'h0000_0001, 32'h0000_0200, 32'h0000_0020);
    tests_run++; if ({out_pc_src, out_target} !== {1'b1, 32'h0000_0220}) begin tests_failed++; $display("FAIL blt_taken got=%b/%h want=1/00000220", out_pc_src, out_target); end
    drive_ctrl(1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 32'h0000_0001, 32'h0000_0200, 32'h0000_0020);
    tests_run++; if (out_pc_src !== 1'b0) begin tests_failed++; $display("FAIL bgeu_not_taken got=%b want=0", out_pc_src); end
    drive_ctrl(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0000_0203, 32'h0000_0300, 32'h0000_0000);
    tests_run++; if ({out_pc_src, out_target, out_write_data, out_reg_write} !== {1'b1, 32'h0000_0202, 32'h0000_0304, 1'b1}) begin tests_failed++; $display("FAIL jalr got=%b/%h/%h/%b want=1/00000202/00000304/1", out_pc_src, out_target, out_write_data, out_reg_write); end
    drive_ctrl(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 32'hFFFF_FFF0, 32'h0000_0020);
    tests_run++; if ({out_pc_src, out_target} !== {1'b1, 32'h0000_0010}) begin tests_failed++; $display("FAIL jal_wrap got=%b/%h want=1/00000010", out_pc_src, out_target); end
    drive_ctrl(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h5555_AAAA, 32'h0, 32'h0);
    tests_run++; if ({out_write_data, out_reg_write, out_write_reg, out_pc_src, stall} !== {32'h5555_AAAA, 1'b1, 5'd3, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL alu_wb got=%h/%b/%0d/%b/%b want=5555aaaa/1/3/0/0", out_write_data, out_reg_write, out_write_reg, out_pc_src, stall); end
    @(posedge clk); #1; set_idle();
    @(negedge clk);
    tests_run++; if (dmem_if.req !== 1'b0) begin tests_failed++; $display("FAIL stray_ready got req=%b want=0", dmem_if.req); end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    set_idle();
    in_mem_reg = 1'b1; in_reg_write = 1'b1; in_funct3 = 3'b010; in_alu_result = 32'h0000_3002;
    @(negedge clk);
    tests_run++; if ({out_misalign, out_reg_write, stall} !== 3'b100) begin tests_failed++; $display("FAIL lw_trap got=%b%b%b want=100", out_misalign, out_reg_write, stall); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (dmem_if.req !== 1'b0) begin tests_failed++; $display("FAIL lw_trap_req got=%b want=0", dmem_if.req); end
    @(posedge clk); #1; set_idle();
`else
    int st, rq; logic [31:0] a, d, wb, e; logic [3:0] s; logic we, rw, to;
    exp_q.push_back(32'hDEAD_BEEF);
    run_access(1'b1, 3'b010, 32'h0000_3002, 32'h0, 32'hDEAD_BEEF, 1, st, rq, a, d, s, we, wb, rw, to);
    e = exp_q.pop_front();
    tests_run++; if (to || a !== 32'h0000_3000 || wb !== e) begin tests_failed++; $display("FAIL lw_unaligned got=%h/%h want=00003000/%h", a, wb, e); end
    tests_run++; if (out_misalign !== 1'b0 || rw !== 1'b1) begin tests_failed++; $display("FAIL lw_unaligned_flag got=%b/%b want=0/1", out_misalign, rw); end
`endif
  endtask

  task automatic test_back_to_back();
    int st, rq; logic [31:0] a, d, wb, e; logic [3:0] s; logic we, rw, to;
    exp_q.push_back(32'h0000_ABCD);
    run_access(1'b1, 3'b101, 32'h0000_5002, 32'h0, 32'hABCD_1234, 1, st, rq, a, d, s, we, wb, rw, to);
    e = exp_q.pop_front();
    tests_run++; if (to || wb !== e || st != 2) begin tests_failed++; $display("FAIL b2b_lhu got=%h stall=%0d want=%h/2", wb, st, e); end
    run_access(1'b0, 3'b000, 32'h0000_5001, 32'h0000_005A, 32'h0, 1, st, rq, a, d, s, we, wb, rw, to);
    tests_run++; if (to || st != 2 || {a, s, d} !== {32'h0000_5000, 4'b0010, 32'h5A5A_5A5A}) begin tests_failed++; $display("FAIL b2b_sb got=%h/%b/%h stall=%0d want=00005000/0010/5a5a5a5a/2", a, s, d, st); end
    exp_q.push_back(32'h0000_007F);
    run_access(1'b1, 3'b000, 32'h0000_5003, 32'h0, 32'h7F00_0000, 2, st, rq, a, d, s, we, wb, rw, to);
    e = exp_q.pop_front();
    tests_run++; if (to || wb !== e || st != 3) begin tests_failed++; $display("FAIL b2b_lb got=%h stall=%0d want=%h/3", wb, st, e); end
    @(posedge clk); #1; set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_store();
    test_load();
    test_branch_jump();
    test_misalign();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the five-stage RV32I pipeline, sitting directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. Issues load/store requests to the data memory over a request/ready handshake, stalls the pipeline until the access completes, aligns store data/strobes and sign/zero-extends load data per funct3, and resolves branches and jumps. Produces the writeback value and the PC redirect consumed by fetch.

## Interface
- No parameters; widths fixed at RV32.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_alu_result  in  32  ALU result: memory address, branch compare bit, or writeback value
- in_zero  in  1  ALU zero flag
- in_funct3  in  3  access size/sign or branch condition
- in_mem_write_data  in  32  store data (rs2)
- in_mem_write / in_mem_reg  in  1  store / load
- in_reg_write  in  1  instruction writes rd
- in_write_reg  in  5  rd
- in_branch / in_jal / in_jalr  in  1  control-flow type
- in_imm, in_PC, in_nextPC  in  32  immediate, instruction PC, PC+4
- dmem_req  out  1  access request, registered
- dmem_we  out  1  write enable, registered
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}), registered
- dmem_wdata  out  32  lane-aligned store data, registered
- dmem_wstrb  out  4  byte strobes, registered
- dmem_ready  in  1  access complete; load data valid same cycle
- dmem_rdata  in  32  load word
- stall  out  1  hold EX/MEM register and all upstream stages
- out_write_data  out  32  writeback value
- out_reg_write  out  1  qualified rd write
- out_write_reg  out  5  rd passthrough
- out_pc_src  out  1  redirect fetch
- out_target  out  32  redirect address
- out_misalign  out  1  misaligned-access flag

## Operation
- FSM states IDLE, WAIT, DONE; reset -> IDLE.
- IDLE: if (in_mem_reg|in_mem_write) and access legal: stall=1, load dmem_* registers, -> WAIT. Otherwise stall=0, stay IDLE.
- WAIT: dmem_req=1, stall=1; on dmem_ready=1: capture dmem_rdata into load register, drop dmem_req at the edge, -> DONE.
- DONE: stall=0, writeback from captured data; -> IDLE unconditionally (no new access started from DONE).
- dmem_ready ignored outside WAIT.
- Store lanes: SB(000) wstrb=1<<a[1:0], wdata=byte replicated ×4; SH(001) wstrb=a[1]?1100:0011, wdata=half replicated ×2; SW(010) wstrb=1111.
- Load extract by a[1:0]: LB(000) sign-ext, LH(001) sign-ext, LW(010), LBU(100) zero-ext, LHU(101) zero-ext; other codes yield the raw word.
- out_write_data: in_jal|in_jalr -> in_nextPC; in_mem_reg -> extracted load; else in_alu_result.
- out_reg_write = in_reg_write & ~stall & ~out_misalign.
- Branch taken: 000 zero; 001 ~zero; 100/110 alu_result[0]; 101/111 ~alu_result[0].
- out_pc_src = in_jal | in_jalr | (in_branch & taken); out_target = in_jalr ? (in_alu_result & ~1) : in_PC + in_imm (32-bit wrap).
- Writeback, redirect, and misalign outputs are combinational from inputs and state; only dmem_*, FSM, and load register are sequential.

## Timing
- Reset values: state IDLE, dmem_req/dmem_we 0, dmem_addr/wdata/wstrb 0, load register 0; hence stall=0, out_misalign=0.
- Non-memory instruction: zero added latency, stall never asserted.
- Load/store presented at cycle N: stall N, N+1..; dmem_req rises N+1; ready at cycle M -> DONE at M+1, stall low at M+1, instruction leaves on edge ending M+1. Minimum 3 cycles (ready at N+1).
- Store with ready at N+1: one write only; dmem_req high exactly one cycle.
- rst during WAIT: next edge -> IDLE, dmem_req 0, pending response discarded.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]≠0, issue no request; out_misalign=1 and out_reg_write=0 while presented, stall=0.
- Undefined: out_misalign tied 0; offending low address bits treated as 0 (half uses a[1] only, word uses lane 0), access proceeds normally.

## Test plan
- Reset: assert rst 2 cycles mid-WAIT -> dmem_req=0, stall=0, state IDLE next cycle.
- SB addr 0x1003, data 0x000000A5, ready at N+1 -> dmem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, stall high 2 cycles.
- LB addr 0x2001, rdata 0x0000_8000, ready after 3 wait cycles -> out_write_data=0xFFFFFF80; LBU same -> 0x00000080; stall 4 cycles.
- BNE zero=0, PC 0x100, imm 0xFFFFFFF8 -> out_pc_src=1, target=0xF8; JALR alu 0x203 -> target 0x202, write_data=nextPC.
- LW addr 0x3002 with MEM_MISALIGN_TRAP_EN -> no dmem_req, out_misalign=1, out_reg_write=0; without -> dmem_addr 0x3000, normal load.
